// File: rtl/part1_reg.sv
// General-purpose n-bit register with decrement/increment/load/clear selected by FunSel.
// All updates happen on the rising clock edge. Reset is synchronous and has priority over enable.
module part1_reg #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   FunSel,
  input  logic [n-1:0] data_in,
  input  logic         enable,
  output logic [n-1:0] data_out
);

  typedef enum logic [1:0] {
    OP_DEC   = 2'b00,
    OP_INC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  op_t          op;
  logic [n-1:0] q;

  always_comb begin
    op = op_t'(FunSel);
  end

  // Arithmetic wraps modulo 2^n and has no carry or borrow output.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      case (op)
        OP_DEC:   q <= q - n'(1);
        OP_INC:   q <= q + n'(1);
        OP_LOAD:  q <= data_in;
        OP_CLEAR: q <= '0;
        default:  q <= '0;
      endcase
    end
  end

  assign data_out = q;

endmodule

// File: tb/tb_part1_reg.sv
// Self-checking bench for part1_reg. It runs 8-bit and 4-bit instances in lockstep and checks
// them against a modular-arithmetic reference model and against the directed test-plan values.
module tb_part1_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fun_sel;
  logic [7:0] din;
  logic       enable;
  logic [7:0] q8;
  logic [3:0] q4;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned m8 = 0;
  int unsigned m4 = 0;
  bit          valid = 1'b0;

  part1_reg #(.n(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .FunSel   (fun_sel),
    .data_in  (din),
    .enable   (enable),
    .data_out (q8)
  );

  part1_reg #(.n(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .FunSel   (fun_sel),
    .data_in  (din[3:0]),
    .enable   (enable),
    .data_out (q4)
  );

  always #5 clk = ~clk;

  function automatic int unsigned ref_next(int unsigned q, bit r, bit e, logic [1:0] f,
                                           int unsigned d, int unsigned modulus);
    if (r) return 0;
    if (!e) return q;
    case (f)
      2'd0:    return (q + modulus - 1) % modulus;
      2'd1:    return (q + 1) % modulus;
      2'd2:    return d % modulus;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge, sample 1 time unit later.
  task automatic step(input string tag, input bit r, input bit e, input logic [1:0] f,
                      input logic [7:0] d);
    @(negedge clk);
    reset   = r;
    enable  = e;
    fun_sel = f;
    din     = d;
    @(posedge clk);
    m8 = ref_next(m8, r, e, f, int'(d), 256);
    m4 = ref_next(m4, r, e, f, int'(d), 16);
    if (r) valid = 1'b1;
    #1;
    if (valid) begin
      check({tag, "/n8"}, q8, m8[7:0]);
      check({tag, "/n4"}, {4'h0, q4}, m4[7:0]);
    end
  endtask

  task automatic expect_const(input string tag, input logic [7:0] e8, input logic [3:0] e4);
    check({tag, "/n8/const"}, q8, e8);
    check({tag, "/n4/const"}, {4'h0, q4}, {4'h0, e4});
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    fun_sel = 2'b00;
    din     = 8'h00;

    // Reset wins over an enabled load.
    step("reset_over_load", 1'b1, 1'b1, 2'b10, 8'h55);
    expect_const("reset_over_load", 8'h00, 4'h0);

    // Disabled: every function is ignored.
    for (int i = 0; i < 4; i++) begin
      step("disabled_hold", 1'b0, 1'b0, 2'(i), 8'h02);
      expect_const("disabled_hold", 8'h00, 4'h0);
    end

    step("load_02", 1'b0, 1'b1, 2'b10, 8'h02);
    expect_const("load_02", 8'h02, 4'h2);
    step("inc", 1'b0, 1'b1, 2'b01, 8'h02);
    expect_const("inc", 8'h03, 4'h3);
    step("dec", 1'b0, 1'b1, 2'b00, 8'h02);
    expect_const("dec", 8'h02, 4'h2);
    step("clear", 1'b0, 1'b1, 2'b11, 8'h06);
    expect_const("clear", 8'h00, 4'h0);
    step("hold_inc_disabled", 1'b0, 1'b0, 2'b01, 8'h06);
    expect_const("hold_inc_disabled", 8'h00, 4'h0);

    // Wrap-around in both directions.
    step("dec_wrap", 1'b0, 1'b1, 2'b00, 8'h00);
    expect_const("dec_wrap", 8'hFF, 4'hF);
    step("inc_wrap", 1'b0, 1'b1, 2'b01, 8'h00);
    expect_const("inc_wrap", 8'h00, 4'h0);
    step("load_max", 1'b0, 1'b1, 2'b10, 8'hFF);
    expect_const("load_max", 8'hFF, 4'hF);
    step("inc_from_max", 1'b0, 1'b1, 2'b01, 8'h00);
    expect_const("inc_from_max", 8'h00, 4'h0);

    // Chained increments, then reset mid-sequence.
    step("load_80", 1'b0, 1'b1, 2'b10, 8'h80);
    expect_const("load_80", 8'h80, 4'h0);
    for (int i = 0; i < 3; i++) step("chain_inc", 1'b0, 1'b1, 2'b01, 8'h00);
    expect_const("chain_inc3", 8'h83, 4'h3);
    step("reset_mid", 1'b1, 1'b1, 2'b01, 8'h00);
    expect_const("reset_mid", 8'h00, 4'h0);
    step("resume_inc", 1'b0, 1'b1, 2'b01, 8'h00);
    expect_const("resume_inc", 8'h01, 4'h1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step("random",
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
